alu_24: RTL and testbench

24-bit arithmetic/logic unit for the 24-bit CPU datapath, sitting between the register-file read ports and the writeback/branch logic. It performs AND, OR, ADD, SUB and XOR on two 24-bit operands and produces a registered result plus Zero, CarryOut and Overflow flags. It is built as 24 one-bit ALU slices in a ripple-carry chain, followed by an output register stage.

---
 rtl/alu_24.sv | 92 +++++++++
 tb/tb_alu_24.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_24.sv
// 24-bit ALU built from one-bit slices in a ripple-carry chain, followed by a
// single output register stage (1-cycle latency, one operation per cycle).

module alu_24_slice (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_bNegate,
    input  logic       i_carry,
    input  logic [1:0] i_op,
    output logic       o_result,
    output logic       o_carry
);

    logic w_bx;
    logic w_sum;

    assign w_bx    = i_b ^ i_bNegate;
    assign w_sum   = i_a ^ w_bx ^ i_carry;
    assign o_carry = (i_a & w_bx) | (i_a & i_carry) | (w_bx & i_carry);

    always_comb begin
        o_result = 1'b0;
        case (i_op)
            2'b00:   o_result = i_a & w_bx;
            2'b01:   o_result = i_a | w_bx;
            2'b10:   o_result = w_sum;
            default: o_result = i_a ^ w_bx;
        endcase
    end

endmodule

module alu_24 #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALUOp,
    input  logic             BNegate,
    output logic             Overflow,
    output logic             Zero,
    output logic             CarryOut,
    output logic [WIDTH-1:0] Result
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_result;
    logic             w_isArith;

    // BNegate doubles as the adder carry-in so ~B + 1 forms the two's complement.
    assign w_carry[0] = BNegate;
    assign w_isArith  = (ALUOp == 2'b10);

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_24_slice u_slice (
            .i_a       (A[i]),
            .i_b       (B[i]),
            .i_bNegate (BNegate),
            .i_carry   (w_carry[i]),
            .i_op      (ALUOp),
            .o_result  (w_result[i]),
            .o_carry   (w_carry[i+1])
        );
    end

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carryOut;
    logic             r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_result   <= w_result;
            r_zero     <= ~|w_result;
            r_carryOut <= w_isArith & w_carry[WIDTH];
            r_overflow <= w_isArith & (w_carry[WIDTH] ^ w_carry[WIDTH-1]);
        end
    end

    assign Result   = r_result;
    assign Zero     = r_zero;
    assign CarryOut = r_carryOut;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_alu_24.sv
// Self-checking bench for alu_24: directed vectors with literal expectations plus
// a per-cycle comparison against an arithmetic reference model.

module tb_alu_24;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] A;
    logic [23:0] B;
    logic [1:0]  ALUOp;
    logic        BNegate;
    logic        Overflow;
    logic        Zero;
    logic        CarryOut;
    logic [23:0] Result;

    int errors = 0;
    int checks = 0;

    alu_24 dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .ALUOp    (ALUOp),
        .BNegate  (BNegate),
        .Overflow (Overflow),
        .Zero     (Zero),
        .CarryOut (CarryOut),
        .Result   (Result)
    );

    always #5 clk = ~clk;

    // Reference model from plain integer arithmetic; returns {Result, Zero, CarryOut, Overflow}.
    function automatic logic [26:0] aluModel(input logic [23:0] a, input logic [23:0] b,
                                             input logic [1:0] op, input logic bn);
        logic [23:0] bx;
        logic [24:0] sum;
        logic [23:0] res;
        logic        c;
        logic        v;
        bx  = bn ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {24'd0, bn};
        case (op)
            2'b00:   res = a & bx;
            2'b01:   res = a | bx;
            2'b10:   res = sum[23:0];
            default: res = a ^ bx;
        endcase
        c = (op == 2'b10) ? sum[24] : 1'b0;
        v = (op == 2'b10) ? ((a[23] == bx[23]) && (res[23] != a[23])) : 1'b0;
        return {res, (res == 24'd0), c, v};
    endfunction

    logic [26:0] modelOut;
    logic        modelValid = 1'b0;

    always @(posedge clk) begin
        if (reset) modelOut <= {24'd0, 1'b1, 1'b0, 1'b0};
        else       modelOut <= aluModel(A, B, ALUOp, BNegate);
        modelValid <= 1'b1;
    end

    // Every cycle, compare registered outputs with the model on the falling edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checks++;
            if ({Result, Zero, CarryOut, Overflow} !== modelOut) begin
                errors++;
                $display("[TB] FAIL model t=%0t got R=%h Z=%b C=%b V=%b expected R=%h Z=%b C=%b V=%b",
                         $time, Result, Zero, CarryOut, Overflow,
                         modelOut[26:3], modelOut[2], modelOut[1], modelOut[0]);
            end
        end
    end

    task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b,
                                 input logic [1:0] op, input logic bn);
        A       = a;
        B       = b;
        ALUOp   = op;
        BNegate = bn;
    endtask

    task automatic checkOutput(input string name, input logic [23:0] r,
                               input logic z, input logic c, input logic v);
        @(posedge clk);
        #2;
        checks++;
        if ({Result, Zero, CarryOut, Overflow} !== {r, z, c, v}) begin
            errors++;
            $display("[TB] FAIL %s got R=%h Z=%b C=%b V=%b expected R=%h Z=%b C=%b V=%b",
                     name, Result, Zero, CarryOut, Overflow, r, z, c, v);
        end
    endtask

    typedef struct {
        string       name;
        logic [23:0] a;
        logic [23:0] b;
        logic [1:0]  op;
        logic        bn;
        logic [23:0] r;
        logic        z;
        logic        c;
        logic        v;
    } vector_t;

    vector_t vectors[$];

    task automatic addVector(input string name, input logic [23:0] a, input logic [23:0] b,
                             input logic [1:0] op, input logic bn, input logic [23:0] r,
                             input logic z, input logic c, input logic v);
        vector_t t;
        t.name = name; t.a = a; t.b = b; t.op = op; t.bn = bn;
        t.r = r; t.z = z; t.c = c; t.v = v;
        vectors.push_back(t);
    endtask

    initial begin
        addVector("and55",     24'd5,       24'd5,  2'b00, 1'b0, 24'd5,       1'b0, 1'b0, 1'b0);
        addVector("and63",     24'd6,       24'd3,  2'b00, 1'b0, 24'd2,       1'b0, 1'b0, 1'b0);
        addVector("or55",      24'd5,       24'd5,  2'b01, 1'b0, 24'd5,       1'b0, 1'b0, 1'b0);
        addVector("or63",      24'd6,       24'd3,  2'b01, 1'b0, 24'd7,       1'b0, 1'b0, 1'b0);
        addVector("xor55",     24'd5,       24'd5,  2'b11, 1'b0, 24'd0,       1'b1, 1'b0, 1'b0);
        addVector("xor63",     24'd6,       24'd3,  2'b11, 1'b0, 24'd5,       1'b0, 1'b0, 1'b0);
        addVector("add10_20",  24'd10,      24'd20, 2'b10, 1'b0, 24'd30,      1'b0, 1'b0, 1'b0);
        addVector("add10_40",  24'd10,      24'd40, 2'b10, 1'b0, 24'd50,      1'b0, 1'b0, 1'b0);
        addVector("addWrap",   24'hFFFFFF,  24'd1,  2'b10, 1'b0, 24'h000000,  1'b1, 1'b1, 1'b0);
        addVector("addOvf",    24'h7FFFFF,  24'd1,  2'b10, 1'b0, 24'h800000,  1'b0, 1'b0, 1'b1);
        addVector("sub10_10",  24'd10,      24'd10, 2'b10, 1'b1, 24'd0,       1'b1, 1'b1, 1'b0);
        addVector("sub40_30",  24'd40,      24'd30, 2'b10, 1'b1, 24'd10,      1'b0, 1'b1, 1'b0);
        addVector("sub0_1",    24'd0,       24'd1,  2'b10, 1'b1, 24'hFFFFFF,  1'b0, 1'b0, 1'b0);
        addVector("subOvf",    24'h800000,  24'd1,  2'b10, 1'b1, 24'h7FFFFF,  1'b0, 1'b1, 1'b1);
        addVector("andNeg63",  24'd6,       24'd3,  2'b00, 1'b1, 24'h000004,  1'b0, 1'b0, 1'b0);
        addVector("orNeg00",   24'd0,       24'd0,  2'b01, 1'b1, 24'hFFFFFF,  1'b0, 1'b0, 1'b0);
        addVector("xorNeg63",  24'd6,       24'd3,  2'b11, 1'b1, 24'hFFFFFA,  1'b0, 1'b0, 1'b0);

        // Reset held for two cycles with arbitrary inputs.
        reset = 1'b1;
        applyStimulus(24'hABCDEF, 24'h123456, 2'b10, 1'b0);
        checkOutput("reset1", 24'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(24'hFFFFFF, 24'h000001, 2'b10, 1'b0);
        checkOutput("reset2", 24'd0, 1'b1, 1'b0, 1'b0);

        reset = 1'b0;
        applyStimulus(24'd5, 24'd5, 2'b00, 1'b0);
        checkOutput("firstAfterReset", 24'd5, 1'b0, 1'b0, 1'b0);

        // Back-to-back: a new vector every cycle.
        foreach (vectors[i]) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].op, vectors[i].bn);
            checkOutput(vectors[i].name, vectors[i].r, vectors[i].z, vectors[i].c, vectors[i].v);
        end

        // Reset arriving with an overflowing add in flight discards it.
        reset = 1'b1;
        applyStimulus(24'h7FFFFF, 24'd1, 2'b10, 1'b0);
        checkOutput("midReset", 24'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(24'd1, 24'd2, 2'b10, 1'b0);
        checkOutput("afterMidReset", 24'd3, 1'b0, 1'b0, 1'b0);

        // Held inputs keep the outputs steady.
        checkOutput("hold", 24'd3, 1'b0, 1'b0, 1'b0);

        // Random operands; the per-cycle model comparison covers these.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(24'($urandom), 24'($urandom), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
            @(posedge clk);
            #2;
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
